// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the two-master memory arbiter.
// Port IDs index the request/grant vectors of rr_arb2.
package mem_arb_pkg;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;
   localparam int   CNT_W  = 32;

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; last_q remembers the most recent winner.
// A lone requester always wins; on a tie the other master gets its turn.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       resetb,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_q;
   logic last_d;

   always_comb begin
      gnt    = 2'b00;
      last_d = last_q;
      if (req[PORT_I] && (!req[PORT_D] || last_q == PORT_D)) begin
         gnt[PORT_I] = 1'b1;
         last_d      = PORT_I;
      end else if (req[PORT_D]) begin
         gnt[PORT_D] = 1'b1;
         last_d      = PORT_D;
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) last_q <= PORT_I;
      else         last_q <= last_d;
   end

endmodule

// File: rtl/mem_arbiter2.sv
// Merges instruction and data ports onto one single-port memory bus,
// routes one-cycle-late read data back, and keeps stall statistics.
module mem_arbiter2
   import mem_arb_pkg::*;
#(
   parameter int SIZE = 4096
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             i_req,
   input  logic [29:0]      i_addr,
   output logic             i_gnt,
   output logic             i_rresp,
   output logic [31:0]      i_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [29:0]      d_addr,
   input  logic [31:0]      d_wdata,
   input  logic [3:0]       d_wstrb,
   output logic             d_gnt,
   output logic             d_rresp,
   output logic [31:0]      d_rdata,
   output logic             m_ready,
   output logic             m_we,
   output logic [29:0]      m_addr,
   output logic [31:0]      m_wdata,
   output logic [3:0]       m_wstrb,
   input  logic             m_rresp,
   input  logic [31:0]      m_rdata,
   output logic [CNT_W-1:0] conflicts,
   output logic [CNT_W-1:0] i_stalls,
   output logic [CNT_W-1:0] d_stalls,
   output logic             err
);

   localparam int ALSB = $clog2(SIZE) - 2;

   logic [1:0] req;
   logic [1:0] gnt;

   logic             rd_pend_q,  rd_pend_d;
   logic             rd_owner_q, rd_owner_d;
   logic             err_q,      err_d;
   logic [CNT_W-1:0] conf_q,     conf_d;
   logic [CNT_W-1:0] istl_q,     istl_d;
   logic [CNT_W-1:0] dstl_q,     dstl_d;

   always_comb begin
      req         = 2'b00;
      req[PORT_I] = i_req;
      req[PORT_D] = d_req;
   end

   rr_arb2 u_arb (
      .clk    (clk),
      .resetb (resetb),
      .req    (req),
      .gnt    (gnt)
   );

   assign i_gnt = gnt[PORT_I];
   assign d_gnt = gnt[PORT_D];

   always_comb begin
      m_ready = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_wstrb = '0;
      unique case (1'b1)
         d_gnt: begin
            m_ready = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_wstrb = d_wstrb;
         end
         i_gnt: begin
            m_ready = 1'b1;
            m_addr  = i_addr;
         end
         default: ;
      endcase
   end

   // Any cycle without a read strobe retires the outstanding owner.
   always_comb begin
      rd_pend_d  = 1'b0;
      rd_owner_d = rd_owner_q;
      if (m_ready && !m_we) begin
         rd_pend_d  = 1'b1;
         rd_owner_d = d_gnt ? PORT_D : PORT_I;
      end
   end

   always_comb begin
      err_d  = err_q | (m_ready & (|m_addr[29:ALSB]));
      conf_d = conf_q;
      istl_d = istl_q;
      dstl_d = dstl_q;
      if (i_req && d_req) conf_d = sat_inc(conf_q);
      if (i_req && !i_gnt) istl_d = sat_inc(istl_q);
      if (d_req && !d_gnt) dstl_d = sat_inc(dstl_q);
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         rd_pend_q  <= 1'b0;
         rd_owner_q <= PORT_I;
         err_q      <= 1'b0;
         conf_q     <= '0;
         istl_q     <= '0;
         dstl_q     <= '0;
      end else begin
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
         err_q      <= err_d;
         conf_q     <= conf_d;
         istl_q     <= istl_d;
         dstl_q     <= dstl_d;
      end
   end

   assign i_rresp   = m_rresp & rd_pend_q & (rd_owner_q == PORT_I);
   assign d_rresp   = m_rresp & rd_pend_q & (rd_owner_q == PORT_D);
   assign i_rdata   = i_rresp ? m_rdata : '0;
   assign d_rdata   = d_rresp ? m_rdata : '0;
   assign conflicts = conf_q;
   assign i_stalls  = istl_q;
   assign d_stalls  = dstl_q;
   assign err       = err_q;

endmodule
